scene_ctrl: RTL and testbench

- Top-level screen sequencer for the music game.
- Consumes the synchronized single-cycle `change` pulse from the clock-domain edge detector, plus menu button pulses and the player's `song_done`.
- Steps the game through TITLE, SELECT, PLAY and RESULT screens, with a timed blanking (fade) interval between screens.
- Drives the screen select to the display mux and one-cycle start/stop/clear strobes to the music player and score logic.

---
 rtl/scene_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_scene_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scene_ctrl.sv
// -----------------------------------------------------------------------------
// scene_ctrl
// Top-level screen sequencer for the music game. Walks the game through the
// TITLE -> SELECT -> PLAY -> RESULT screens, inserting a timed blanking (fade)
// interval between every pair of screens, and issues one-cycle strobes to the
// music player and score logic.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   change     advance / confirm / abort command (one-cycle pulse)
//   btn_up     menu cursor up (one-cycle pulse)
//   btn_down   menu cursor down (one-cycle pulse)
//   song_done  end-of-song pulse from the music player
//   scene      current screen: 0 TITLE, 1 SELECT, 2 PLAY, 3 RESULT
//   song_sel   selected song index, 0..NSONGS-1
//   blank      high while a fade interval is in progress
//   play_start one-cycle strobe: begin playback of song_sel
//   play_stop  one-cycle strobe: abort playback
//   score_clr  one-cycle strobe: clear score counters
// -----------------------------------------------------------------------------
module scene_ctrl #(
  parameter int NSONGS       = 4,
  parameter int SEL_W        = 2,
  parameter int FADE_CYCLES  = 16,
  parameter int RESULT_TICKS = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             song_done,
  output logic [1:0]       scene,
  output logic [SEL_W-1:0] song_sel,
  output logic             blank,
  output logic             play_start,
  output logic             play_stop,
  output logic             score_clr
);

  // The fade counter only ever holds FADE_CYCLES-1 down to 0 and the result
  // counter 0 up to RESULT_TICKS-1, so log2 of the parameter is enough bits.
  localparam int FW = (FADE_CYCLES  > 1) ? $clog2(FADE_CYCLES)  : 1;
  localparam int RW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

  localparam logic [FW-1:0]    FADE_LAST = FW'(FADE_CYCLES - 1);
  localparam logic [RW-1:0]    RES_LAST  = RW'(RESULT_TICKS - 1);
  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NSONGS - 1);

  localparam logic [1:0] SC_TITLE  = 2'd0;
  localparam logic [1:0] SC_SELECT = 2'd1;
  localparam logic [1:0] SC_PLAY   = 2'd2;
  localparam logic [1:0] SC_RESULT = 2'd3;

  // Stable states share their encoding with the scene code they display, so
  // leaving FADE is just a zero-extension of the registered target.
  typedef enum logic [2:0] {
    ST_TITLE  = 3'd0,
    ST_SELECT = 3'd1,
    ST_PLAY   = 3'd2,
    ST_RESULT = 3'd3,
    ST_FADE   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [1:0]       target, target_n;
  logic [FW-1:0]    fade_cnt, fade_cnt_n;
  logic [RW-1:0]    res_cnt, res_cnt_n;
  logic [1:0]       scene_n;
  logic [SEL_W-1:0] sel_n;
  logic             blank_n, start_n, stop_n, clr_n;
  logic             req;
  logic [1:0]       req_target;

  // State and every output live in this one register bank, so all outputs
  // come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_TITLE;
      target     <= SC_TITLE;
      fade_cnt   <= '0;
      res_cnt    <= '0;
      scene      <= SC_TITLE;
      song_sel   <= '0;
      blank      <= 1'b0;
      play_start <= 1'b0;
      play_stop  <= 1'b0;
      score_clr  <= 1'b0;
    end else begin
      state      <= state_n;
      target     <= target_n;
      fade_cnt   <= fade_cnt_n;
      res_cnt    <= res_cnt_n;
      scene      <= scene_n;
      song_sel   <= sel_n;
      blank      <= blank_n;
      play_start <= start_n;
      play_stop  <= stop_n;
      score_clr  <= clr_n;
    end
  end

  // Stable states only raise a fade request; the shared block at the bottom
  // turns any request into the FADE entry. FADE ignores every input and just
  // counts down, then lands on the target scene.
  always_comb begin
    state_n    = state;
    target_n   = target;
    fade_cnt_n = fade_cnt;
    res_cnt_n  = res_cnt;
    scene_n    = scene;
    sel_n      = song_sel;
    blank_n    = blank;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    clr_n      = 1'b0;
    req        = 1'b0;
    req_target = target;

    case (state)
      ST_TITLE: begin
        if (change) begin
          req        = 1'b1;
          req_target = SC_SELECT;
        end
      end
      ST_SELECT: begin
        if (change) begin
          req        = 1'b1;
          req_target = SC_PLAY;
        end else if (btn_up && !btn_down) begin
          sel_n = (song_sel == SEL_MAX) ? '0 : song_sel + 1'b1;
        end else if (btn_down && !btn_up) begin
          sel_n = (song_sel == '0) ? SEL_MAX : song_sel - 1'b1;
        end
      end
      ST_PLAY: begin
        // A finished song outranks a simultaneous abort, and then no stop
        // strobe is needed because the player has already ended.
        if (song_done) begin
          req        = 1'b1;
          req_target = SC_RESULT;
        end else if (change) begin
          req        = 1'b1;
          req_target = SC_SELECT;
          stop_n     = 1'b1;
        end
      end
      ST_RESULT: begin
        if (change || res_cnt == RES_LAST) begin
          req        = 1'b1;
          req_target = SC_SELECT;
          res_cnt_n  = '0;
        end else begin
          res_cnt_n = res_cnt + 1'b1;
        end
      end
      ST_FADE: begin
        if (fade_cnt == '0) begin
          state_n = state_t'({1'b0, target});
          scene_n = target;
          blank_n = 1'b0;
          if (target == SC_PLAY) begin
            start_n = 1'b1;
            clr_n   = 1'b1;
          end
        end else begin
          fade_cnt_n = fade_cnt - 1'b1;
        end
      end
      default: begin
        state_n = ST_TITLE;
      end
    endcase

    if (req) begin
      state_n    = ST_FADE;
      target_n   = req_target;
      blank_n    = 1'b1;
      fade_cnt_n = FADE_LAST;
    end
  end

endmodule

// File: tb/tb_scene_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scene_ctrl
// Drives scene_ctrl with a directed walk through every screen followed by
// random button/command traffic and occasional asynchronous resets. A
// timestamp-based reference model predicts the outputs after each clock edge
// and queues them; a separate monitor pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_scene_ctrl;

  localparam int NSONGS       = 3;
  localparam int SEL_W        = 2;
  localparam int FADE_CYCLES  = 4;
  localparam int RESULT_TICKS = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             change = 1'b0;
  logic             btn_up = 1'b0;
  logic             btn_down = 1'b0;
  logic             song_done = 1'b0;
  logic [1:0]       scene;
  logic [SEL_W-1:0] song_sel;
  logic             blank, play_start, play_stop, score_clr;

  typedef struct packed {
    logic [1:0] scene;
    logic [1:0] sel;
    logic       blank;
    logic       start;
    logic       stop;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept as timestamps rather than counters.
  int cyc        = 0;
  int m_scene    = 0;
  int m_sel      = 0;
  bit m_fading   = 0;
  int m_target   = 0;
  int m_fade_end = 0;
  int m_res_ent  = 0;

  scene_ctrl #(
    .NSONGS(NSONGS), .SEL_W(SEL_W),
    .FADE_CYCLES(FADE_CYCLES), .RESULT_TICKS(RESULT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .change(change), .btn_up(btn_up),
    .btn_down(btn_down), .song_done(song_done), .scene(scene),
    .song_sel(song_sel), .blank(blank), .play_start(play_start),
    .play_stop(play_stop), .score_clr(score_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_scene  = 0;
    m_sel    = 0;
    m_fading = 0;
    m_target = 0;
  endtask

  // One clock edge of the screen rules at edge number cyc.
  task automatic modelStep(input bit ch, input bit up, input bit dn, input bit done,
                           output exp_t e);
    bit start = 0, stop = 0, fade_req = 0;
    int tgt = 0;
    if (m_fading) begin
      if (cyc == m_fade_end) begin
        m_fading = 0;
        m_scene  = m_target;
        if (m_scene == 2) start = 1;
        if (m_scene == 3) m_res_ent = cyc;
      end
    end else begin
      case (m_scene)
        0: if (ch) begin fade_req = 1; tgt = 1; end
        1: begin
          if (ch) begin fade_req = 1; tgt = 2; end
          else if (up && !dn) m_sel = (m_sel + 1) % NSONGS;
          else if (dn && !up) m_sel = (m_sel + NSONGS - 1) % NSONGS;
        end
        2: begin
          if (done) begin fade_req = 1; tgt = 3; end
          else if (ch) begin fade_req = 1; tgt = 1; stop = 1; end
        end
        default: begin
          if (ch || (cyc - m_res_ent) == RESULT_TICKS) begin fade_req = 1; tgt = 1; end
        end
      endcase
      if (fade_req) begin
        m_fading   = 1;
        m_target   = tgt;
        m_fade_end = cyc + FADE_CYCLES;
      end
    end
    e.scene = 2'(m_scene);
    e.sel   = 2'(m_sel);
    e.blank = m_fading;
    e.start = start;
    e.stop  = stop;
    e.clr   = start;
  endtask

  // Called just after a posedge: presents inputs for the next edge, then
  // queues the prediction for what the DUT shows after that edge.
  task automatic applyStimulus(input bit ch, input bit up, input bit dn, input bit done);
    exp_t e;
    change    = ch;
    btn_up    = up;
    btn_down  = dn;
    song_done = done;
    @(posedge clk);
    #1;
    cyc++;
    modelStep(ch, up, dn, done, e);
    exp_q.push_back(e);
    change    = 1'b0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    song_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  // Reset is raised between edges and must clear outputs without a clock.
  task automatic asyncReset();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("rst_scene", int'(scene), 0);
    checkOutput("rst_sel", int'(song_sel), 0);
    checkOutput("rst_blank", int'(blank), 0);
    checkOutput("rst_strobes", int'({play_start, play_stop, score_clr}), 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: one prediction per clock edge, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scene", int'(scene), int'(e.scene));
        checkOutput("song_sel", int'(song_sel), int'(e.sel));
        checkOutput("blank", int'(blank), int'(e.blank));
        checkOutput("play_start", int'(play_start), int'(e.start));
        checkOutput("play_stop", int'(play_stop), int'(e.stop));
        checkOutput("score_clr", int'(score_clr), int'(e.clr));
      end
    end
  end

  initial begin
    int r;
    @(posedge clk);
    #1;
    checkOutput("init_scene", int'(scene), 0);
    checkOutput("init_blank", int'(blank), 0);
    checkOutput("init_strobes", int'({play_start, play_stop, score_clr}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();

    $display("[TB] directed walk");
    idle(9);
    applyStimulus(1, 0, 0, 0);
    idle(5);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    idle(7);
    applyStimulus(0, 0, 0, 1);
    idle(5);
    idle(12);
    idle(5);
    applyStimulus(1, 0, 0, 0);
    idle(6);
    applyStimulus(1, 0, 0, 0);
    idle(6);
    applyStimulus(1, 0, 0, 0);
    idle(6);
    applyStimulus(1, 0, 0, 1);
    idle(7);
    applyStimulus(1, 0, 0, 0);
    idle(20);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    idle(3);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    asyncReset();
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        asyncReset();
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end
    end
    idle(2);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
